// File: rtl/text_cursor_ctrl_pkg.sv
// Shared constants and state encoding for the text cursor controller.
// Optional blink output is enabled with CURSOR_BLINK_EN.
package text_pkg;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;
  localparam logic [7:0] PR_LO = 8'h20;
  localparam logic [7:0] PR_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CLR_ROW,
    CLR_ALL
  } state_e;

endpackage

// File: rtl/text_cursor_ctrl_if.sv
// UART byte input and character-RAM write port of the cursor controller.
// cursor_on exists only when CURSOR_BLINK_EN is defined.
interface text_cursor_if #(
  parameter int ROW_W = 2,
  parameter int COL_W = 5
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [7:0]       wr_data;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic             busy;
  logic             overflow;
`ifdef CURSOR_BLINK_EN
  logic             cursor_on;
`endif

  modport master (
    output rx_data, rx_valid,
    input  wr_en, wr_row, wr_col, wr_data,
    input  cur_row, cur_col, busy, overflow
`ifdef CURSOR_BLINK_EN
    , input cursor_on
`endif
  );

  modport slave (
    input  rx_data, rx_valid,
    output wr_en, wr_row, wr_col, wr_data,
    output cur_row, cur_col, busy, overflow
`ifdef CURSOR_BLINK_EN
    , output cursor_on
`endif
  );

endinterface

// File: rtl/text_clear_seq.sv
// Address counter shared by row clear and full-screen clear.
// Counts from 0 after start; done on the last cell of the selected span.
module text_clear_seq #(
  parameter int COL_W = 5,
  parameter int ROW_W = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   all_i,
  output logic [ROW_W+COL_W-1:0] addr_o,
  output logic                   done_o
);

  localparam int AW = ROW_W + COL_W;

  logic [AW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;
  logic          all_q, all_d;

  assign addr_o = cnt_q;
  assign done_o = act_q &
                  (all_q ? (&cnt_q) : (&cnt_q[COL_W-1:0]));

  always_comb begin
    cnt_d = cnt_q;
    act_d = act_q;
    all_d = all_q;
    if (start_i) begin
      cnt_d = '0;
      act_d = 1'b1;
      all_d = all_i;
    end else if (done_o) begin
      act_d = 1'b0;
    end else if (act_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      act_q <= 1'b0;
      all_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      all_q <= all_d;
    end
  end

endmodule

// File: rtl/text_cursor_ctrl.sv
// Write-side sequencer for the VGA text RAM, fed by UART byte strobes.
// Define CURSOR_BLINK_EN to add the blinking cursor_on output.
module text_cursor_ctrl
  import text_pkg::*;
#(
  parameter int         COLS      = 32,
  parameter int         ROWS      = 4,
  parameter int         COL_W     = 5,
  parameter int         ROW_W     = 2,
  parameter logic [7:0] FILL_CHAR = 8'h20
`ifdef CURSOR_BLINK_EN
  , parameter int       BLINK_DIV = 25000000
`endif
) (
  input  logic          clk,
  input  logic          reset,
  text_cursor_if.slave  bus
);

  localparam int AW = ROW_W + COL_W;

  state_e           state_q, state_d, tgt_q, tgt_d;
  logic             full_q, full_d;
  logic [7:0]       hold_q, hold_d;
  logic             wr_en_q, wr_en_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             ovf_q, ovf_d;
  logic             clr_start, clr_all, clr_done;
  logic [AW-1:0]    clr_addr, clr_nxt;
  logic             leave, is_pr, is_nl, is_bs, is_ff;
  logic [ROW_W-1:0] row_inc;

  text_clear_seq #(.COL_W(COL_W), .ROW_W(ROW_W)) u_clr (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (clr_start),
    .all_i   (clr_all),
    .addr_o  (clr_addr),
    .done_o  (clr_done)
  );

  assign clr_nxt = clr_addr + 1'b1;
  assign leave   = (state_q == IDLE) && full_q;
  assign is_pr   = (hold_q >= PR_LO) && (hold_q <= PR_HI);
  assign is_nl   = (hold_q == CC_LF) || (hold_q == CC_CR);
  assign is_bs   = (hold_q == CC_BS);
  assign is_ff   = (hold_q == CC_FF);
  assign row_inc = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    full_d    = full_q;
    hold_d    = hold_q;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_col_d  = wr_col_q;
    wr_data_d = wr_data_q;
    row_d     = row_q;
    col_d     = col_q;
    ovf_d     = 1'b0;
    clr_start = 1'b0;
    clr_all   = 1'b0;

    // The slot frees up on the cycle it is consumed, so a back-to-back byte fits.
    if (leave) full_d = 1'b0;
    if (bus.rx_valid) begin
      if (full_q && !leave) begin
        ovf_d = 1'b1;
      end else begin
        full_d = 1'b1;
        hold_d = bus.rx_data;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (full_q) begin
          // Decode here so the write is registered into the EXEC cycle.
          state_d = EXEC;
          tgt_d   = IDLE;
          unique case (1'b1)
            is_pr: begin
              wr_en_d   = 1'b1;
              wr_row_d  = row_q;
              wr_col_d  = col_q;
              wr_data_d = hold_q;
              if (col_q == COL_W'(COLS - 1)) begin
                col_d = '0;
                row_d = row_inc;
                tgt_d = CLR_ROW;
              end else begin
                col_d = col_q + 1'b1;
              end
            end
            is_nl: begin
              col_d = '0;
              row_d = row_inc;
              tgt_d = CLR_ROW;
            end
            is_bs: begin
              if (col_q != '0) begin
                col_d     = col_q - 1'b1;
                wr_en_d   = 1'b1;
                wr_row_d  = row_q;
                wr_col_d  = col_q - 1'b1;
                wr_data_d = FILL_CHAR;
              end else if (row_q != '0) begin
                row_d     = row_q - 1'b1;
                col_d     = '1;
                wr_en_d   = 1'b1;
                wr_row_d  = row_q - 1'b1;
                wr_col_d  = '1;
                wr_data_d = FILL_CHAR;
              end
            end
            is_ff:   tgt_d = CLR_ALL;
            default: ;
          endcase
        end
      end
      EXEC: begin
        state_d = tgt_q;
        if (tgt_q != IDLE) begin
          clr_start = 1'b1;
          clr_all   = (tgt_q == CLR_ALL);
          wr_en_d   = 1'b1;
          wr_row_d  = (tgt_q == CLR_ALL) ? '0 : row_q;
          wr_col_d  = '0;
          wr_data_d = FILL_CHAR;
        end
      end
      CLR_ROW, CLR_ALL: begin
        if (clr_done) begin
          state_d = IDLE;
          if (state_q == CLR_ALL) begin
            row_d = '0;
            col_d = '0;
          end
        end else begin
          wr_en_d   = 1'b1;
          wr_col_d  = clr_nxt[COL_W-1:0];
          wr_row_d  = (state_q == CLR_ALL) ?
                      clr_nxt[AW-1:COL_W] : row_q;
          wr_data_d = FILL_CHAR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tgt_q     <= IDLE;
      full_q    <= 1'b0;
      hold_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_col_q  <= '0;
      wr_data_q <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      full_q    <= full_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_col_q  <= wr_col_d;
      wr_data_q <= wr_data_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_row   = wr_row_q;
  assign bus.wr_col   = wr_col_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.cur_row  = row_q;
  assign bus.cur_col  = col_q;
  assign bus.busy     = (state_q == CLR_ROW) ||
                        (state_q == CLR_ALL);
  assign bus.overflow = ovf_q;

`ifdef CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);

  logic [BW-1:0] blk_q, blk_d;
  logic          on_q, on_d;
  logic          exec_wr;

  assign exec_wr = leave && wr_en_d;

  always_comb begin
    blk_d = blk_q + 1'b1;
    on_d  = on_q;
    if (exec_wr) begin
      blk_d = '0;
      on_d  = 1'b1;
    end else if (blk_q == BW'(BLINK_DIV - 1)) begin
      blk_d = '0;
      on_d  = ~on_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q <= '0;
      on_q  <= 1'b1;
    end else begin
      blk_q <= blk_d;
      on_q  <= on_d;
    end
  end

  assign bus.cursor_on = on_q;
`endif

endmodule

// File: doc/text_cursor_ctrl.md
Name: text_cursor_ctrl

Overview:
- Write-side sequencer for the character RAM that backs the VGA text display.
- Takes received bytes from the UART as a synchronous one-cycle strobe, interprets printable and control codes, and tracks the write cursor (row, col).
- Drives the RAM write port (we, row, col, data), including multi-cycle row clears and a full-screen clear.
- Replaces ad-hoc cursor logic clocked off the UART strobe; everything runs on the system clock.

Parameters:
- COLS, 32, characters per row; must be a power of two.
- ROWS, 4, rows in the buffer; must be a power of two.
- COL_W, 5, column address width, equal to log2(COLS).
- ROW_W, 2, row address width, equal to log2(ROWS).
- FILL_CHAR, 8'h20, byte written by all clear and erase operations.
- BLINK_DIV, 25000000, clk cycles per cursor-blink half period; used only when CURSOR_BLINK_EN is defined.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous reset, active-low.
- rx_data  in  8  received byte; valid only while rx_valid is high.
- rx_valid  in  1  one-cycle strobe, synchronous to clk.
- wr_en  out  1  RAM write enable.
- wr_row  out  ROW_W  RAM write row.
- wr_col  out  COL_W  RAM write column.
- wr_data  out  8  RAM write data.
- cur_row  out  ROW_W  current cursor row.
- cur_col  out  COL_W  current cursor column.
- busy  out  1  high while a row clear or full clear is in progress.
- overflow  out  1  one-cycle pulse when a byte is dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: wr_en=0, wr_row=0, wr_col=0, wr_data=0, cur_row=0, cur_col=0, busy=0, overflow=0.
  - State returns to IDLE and the holding register is emptied.
  - Reset asserted mid-clear aborts the clear immediately; cells already written stay written.
- States: IDLE, EXEC, CLR_ROW, CLR_ALL.
- Input capture: rx_valid is sampled every cycle into a one-entry holding register.
  - If the register is already full, the new byte is dropped and overflow pulses for 1 cycle.
  - The held byte is never overwritten by a later byte.
- IDLE -> EXEC: when the holding register is full. The register empties on leaving IDLE, so a byte sent one cycle after another still fits.
- EXEC (1 cycle) decodes the byte and returns to IDLE unless noted:
  - 0x20..0x7E (printable): wr_en=1, wr_data=byte at (cur_row, cur_col).
    - cur_col below COLS-1: cur_col += 1.
    - cur_col = COLS-1: cur_col=0, cur_row=(cur_row+1) mod ROWS, then go to CLR_ROW.
  - 0x0A or 0x0D (newline): cur_col=0, cur_row=(cur_row+1) mod ROWS, then go to CLR_ROW.
  - 0x08 (backspace):
    - cur_col above 0: cur_col -= 1 and write FILL_CHAR at the new position.
    - cur_col=0 and cur_row above 0: move to (cur_row-1, COLS-1) and write FILL_CHAR there.
    - At (0,0): no operation, no write.
  - 0x0C (form feed): go to CLR_ALL.
  - Any other byte: ignored, no write.
- CLR_ROW: busy=1; wr_en=1 for exactly COLS consecutive cycles, wr_row=cur_row, wr_col=0..COLS-1, wr_data=FILL_CHAR. Then IDLE.
- CLR_ALL: busy=1; wr_en=1 for ROWS*COLS cycles, row-major from (0,0) to (ROWS-1, COLS-1). Cursor set to (0,0) on completion. Then IDLE.
- Latency: rx_valid in cycle N, with IDLE and the register empty, gives wr_en in cycle N+2.
- Output timing: wr_* are registered; cursor outputs update in the same cycle as the associated write.
- Arithmetic: all cursor arithmetic wraps within ROW_W/COL_W bits; no saturation.

Optional Feature:
- CURSOR_BLINK_EN defined:
  - Adds output cursor_on, 1 bit, reset value 1.
  - cursor_on toggles every BLINK_DIV cycles.
  - Any executed write forces cursor_on=1 and restarts the counter.
- Not defined: no cursor_on port and no blink counter.

Decomposition:
- Shared package text_pkg holds the control-code constants (CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D), the printable range bounds (8'h20, 8'h7E), and the state enum.
- One sub-module, text_clear_seq: address counter plus done flag, used by both CLR_ROW and CLR_ALL. Inputs are start and whole-screen select.

Test Plan:
- Reset, then send 'A' (0x41) -> one write of (0,0,0x41) two cycles after the strobe; cursor becomes (0,1).
- Send 32 'x' bytes at slow spacing -> writes to cols 0..31 of row 0; then 32 cycles of FILL_CHAR writes on row 1 with busy=1; cursor (1,0).
- At (3,5), send 0x0D -> row 0 cleared over 32 cycles; cursor (0,0), confirming row wrap.
- Backspace: at (2,0) send 0x08 -> write 0x20 at (1,31), cursor (1,31); at (0,0) send 0x08 -> no write, cursor unchanged.
- Send 0x0C -> exactly 128 consecutive writes of 0x20 in row-major order; busy high for 128 cycles; cursor (0,0).
- During a CLR_ROW, send 3 strobes -> first held and executed after busy falls; second and third each produce one overflow pulse and no write.
